pio_host_if: RTL and testbench
==============================

Name: pio_host_if

Overview:
- Responder side of the PIO host command interface: decodes the per-cycle action/index/mindex/din stream issued by the host.
- Holds all host-visible PIO configuration: the instruction memory and the per-machine registers.
- Turns PULL, PUSH and IMM actions into handshakes toward the per-machine FIFOs and execution cores.
- Sits between the host (CPU bus bridge or testbench) and the state-machine cores inside the pio top level.

Parameters:
- NUM_SM, 4, number of state machines; mindex width is clog2(NUM_SM).
- IMEM_DEPTH, 32, instruction memory words; index width is clog2(IMEM_DEPTH).

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- action  in  4  0 NONE, 1 INSTR, 2 PEND, 3 PULL, 4 PUSH, 5 GRPS, 6 EN, 7 DIV, 8 SIDES, 9 IMM, 10 SHIFT, 11 IPINS, 12 IDIRS; 13-15 reserved.
- index  in  5  instruction memory address for INSTR.
- mindex  in  2  target machine for every action except INSTR.
- din  in  32  action payload.
- dout  out  32  last word popped by PUSH.
- full  out  NUM_SM  tx_full passthrough.
- empty  out  NUM_SM  rx_empty passthrough.
- imem_raddr  in  5  core fetch address.
- imem_rdata  out  16  imem[imem_raddr], combinational read.
- cfg_pend  out  NUM_SM*5  wrap top per machine.
- cfg_div  out  NUM_SM*24  16.8 fixed-point divider per machine.
- cfg_grps  out  NUM_SM*32  pin-group word per machine.
- cfg_en  out  NUM_SM  machine enable.
- cfg_sides  out  NUM_SM*6  side-set config.
- cfg_shift  out  NUM_SM*16  shift config.
- cfg_ipins  out  NUM_SM*32  initial pins.
- cfg_idirs  out  NUM_SM*32  initial directions.
- tx_push  out  NUM_SM  one-cycle TX FIFO write strobe.
- tx_data  out  32  TX write data.
- tx_full  in  NUM_SM  TX FIFO full.
- rx_pop  out  NUM_SM  one-cycle RX FIFO read strobe.
- rx_data  in  NUM_SM*32  RX FIFO head words.
- rx_empty  in  NUM_SM  RX FIFO empty.
- imm_valid  out  NUM_SM  immediate instruction pending.
- imm_instr  out  NUM_SM*16  pending immediate instruction.
- imm_ready  in  NUM_SM  core accepts the immediate.

Behaviour:
- Reset values (all registered outputs):
  - imem all 16'h0000; cfg_pend 5'd31 per machine; cfg_div 24'h000100 per machine.
  - All other cfg_* 0; dout 0; tx_push, rx_pop and imm_valid 0; imm_instr 0.
- Sampling: action is sampled every rising edge. Every effect lands on that edge and is visible from the next cycle, so write-to-output latency is 1 cycle.
- NONE and reserved codes: no state change. All strobes stay low.
- INSTR: imem[index] <= din[15:0]; other din bits are ignored. The imem read port is combinational, so writing and reading the same address returns the new value the cycle after the edge.
- PEND: cfg_pend[mindex] <= din[4:0].
- DIV: cfg_div[mindex] <= din[23:0].
- GRPS, IPINS and IDIRS: store the full 32 bits.
- EN: cfg_en[mindex] <= din[0].
- SIDES: stores din[5:0].
- SHIFT: stores din[15:0].
- PULL:
  - If tx_full[mindex]=0: tx_push[mindex] is high for exactly one cycle and tx_data=din, both registered.
  - If tx_full[mindex]=1: the word is dropped and no strobe is issued.
- PUSH:
  - If rx_empty[mindex]=0: dout <= rx_data[mindex] and rx_pop[mindex] is high for one cycle.
  - If empty: dout holds its value and there is no pop.
- IMM:
  - imm_instr[mindex] <= din[15:0] and imm_valid[mindex] <= 1.
  - valid holds until the cycle where imm_valid && imm_ready; it clears on the following edge.
  - A new IMM to a machine that is still pending overwrites imm_instr and keeps valid high.
  - An IMM on the same edge as the acceptance handshake re-arms valid with the new instruction, so it is not lost.
- Back-to-back actions: one action per cycle is accepted with no bubbles. Strobes from consecutive PULLs to the same machine appear as a continuous high level on tx_push, one word per cycle.
- Reset mid-operation: an asserted reset clears everything immediately (asynchronous). Pending IMMs and strobes are abandoned.

Decomposition:
- Package pio_pkg:
  - Action code localparams (NONE..IDIRS).
  - Field widths (INSTR_W=16, DIV_W=24, PEND_W=5, SIDES_W=6, SHIFT_W=16).
  - Reset constants (DIV_RESET=24'h000100, PEND_RESET=31).
- Sub-module pio_imm_slot: a per-machine IMM valid/instr holding register with the ready handshake, instantiated NUM_SM times.

Test Plan:
- Reset, then INSTR idx0=0xE081 and idx1=0xE000, then read imem_raddr=0/1 -> imem_rdata 0xE081/0xE000. Unwritten idx5 -> 0x0000.
- mindex=0: PEND 1, DIV 0x0280, GRPS 0x04000000, EN 1 -> cfg_pend[0]=1, cfg_div[0]=0x000280, cfg_grps[0]=0x04000000, cfg_en[0]=1. cfg_div[1..3] stay 0x000100.
- PULL 0xDEADBEEF to machine 2 with tx_full=0 -> tx_push[2] high one cycle with tx_data 0xDEADBEEF. Repeat with tx_full[2]=1 -> no strobe.
- PUSH machine 1 with rx_data[1]=0x12345678 and not empty -> rx_pop[1] pulse and dout=0x12345678. PUSH again with empty=1 -> dout unchanged, no pop.
- IMM 0xE001 on machine 0 with imm_ready=0 for 3 cycles -> imm_valid held, imm_instr 0xE001. Then ready=1 -> valid clears the next cycle. Overwrite with 0xE000 while pending -> instr 0xE000.
- Drop reset mid-sequence after several writes -> all cfg_* return to reset values immediately, imm_valid and strobes go to 0.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared action codes, field widths and reset constants for the PIO host command interface.
package pio_pkg;
    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_PULL  = 4'd3;
    localparam logic [3:0] ACT_PUSH  = 4'd4;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_SIDES = 4'd8;
    localparam logic [3:0] ACT_IMM   = 4'd9;
    localparam logic [3:0] ACT_SHIFT = 4'd10;
    localparam logic [3:0] ACT_IPINS = 4'd11;
    localparam logic [3:0] ACT_IDIRS = 4'd12;

    localparam int INSTR_W = 16;
    localparam int DIV_W   = 24;
    localparam int PEND_W  = 5;
    localparam int SIDES_W = 6;
    localparam int SHIFT_W = 16;

    localparam logic [DIV_W-1:0]  DIV_RESET  = 24'h000100;
    localparam logic [PEND_W-1:0] PEND_RESET = 5'd31;
endpackage

// File: rtl/pio_imm_slot.sv
// One machine's pending immediate instruction: held until the core accepts it.
module pio_imm_slot
    import pio_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o
);
    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;

    // A load on the acceptance edge wins so the new instruction is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
endmodule

// File: rtl/pio_host_if.sv
// Host command responder: decodes one action per cycle into PIO config, imem writes and FIFO/IMM handshakes.
module pio_host_if
    import pio_pkg::*;
#(
    parameter int NUM_SM     = 4,
    parameter int IMEM_DEPTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [3:0]                      action,
    input  logic [$clog2(IMEM_DEPTH)-1:0]   index,
    input  logic [$clog2(NUM_SM)-1:0]       mindex,
    input  logic [31:0]                     din,
    output logic [31:0]                     dout,
    output logic [NUM_SM-1:0]               full,
    output logic [NUM_SM-1:0]               empty,
    input  logic [$clog2(IMEM_DEPTH)-1:0]   imem_raddr,
    output logic [INSTR_W-1:0]              imem_rdata,
    output logic [NUM_SM*PEND_W-1:0]        cfg_pend,
    output logic [NUM_SM*DIV_W-1:0]         cfg_div,
    output logic [NUM_SM*32-1:0]            cfg_grps,
    output logic [NUM_SM-1:0]               cfg_en,
    output logic [NUM_SM*SIDES_W-1:0]       cfg_sides,
    output logic [NUM_SM*SHIFT_W-1:0]       cfg_shift,
    output logic [NUM_SM*32-1:0]            cfg_ipins,
    output logic [NUM_SM*32-1:0]            cfg_idirs,
    output logic [NUM_SM-1:0]               tx_push,
    output logic [31:0]                     tx_data,
    input  logic [NUM_SM-1:0]               tx_full,
    output logic [NUM_SM-1:0]               rx_pop,
    input  logic [NUM_SM*32-1:0]            rx_data,
    input  logic [NUM_SM-1:0]               rx_empty,
    output logic [NUM_SM-1:0]               imm_valid,
    output logic [NUM_SM*INSTR_W-1:0]       imm_instr,
    input  logic [NUM_SM-1:0]               imm_ready
);
    logic [INSTR_W-1:0]                    imem_q [IMEM_DEPTH];
    logic [NUM_SM-1:0][PEND_W-1:0]         pend_q;
    logic [NUM_SM-1:0][DIV_W-1:0]          div_q;
    logic [NUM_SM-1:0][31:0]               grps_q, ipins_q, idirs_q;
    logic [NUM_SM-1:0]                     en_q;
    logic [NUM_SM-1:0][SIDES_W-1:0]        sides_q;
    logic [NUM_SM-1:0][SHIFT_W-1:0]        shift_q;
    logic [NUM_SM-1:0]                     tx_push_q, tx_push_d, rx_pop_q, rx_pop_d;
    logic [31:0]                           tx_data_q, dout_q;
    logic [NUM_SM-1:0][31:0]               rx_words;
    logic [NUM_SM-1:0][INSTR_W-1:0]        imm_instr_w;
    logic [NUM_SM-1:0]                     sel, imm_load;

    assign rx_words = rx_data;

    always_comb begin
        sel         = '0;
        sel[mindex] = 1'b1;
        tx_push_d   = (action == ACT_PULL) ? (sel & ~tx_full)  : '0;
        rx_pop_d    = (action == ACT_PUSH) ? (sel & ~rx_empty) : '0;
        imm_load    = (action == ACT_IMM)  ? sel               : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IMEM_DEPTH; i++) imem_q[i] <= '0;
        end else if (action == ACT_INSTR) begin
            imem_q[index] <= din[INSTR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q    <= {NUM_SM{PEND_RESET}};
            div_q     <= {NUM_SM{DIV_RESET}};
            grps_q    <= '0;
            ipins_q   <= '0;
            idirs_q   <= '0;
            en_q      <= '0;
            sides_q   <= '0;
            shift_q   <= '0;
            tx_push_q <= '0;
            rx_pop_q  <= '0;
            tx_data_q <= '0;
            dout_q    <= '0;
        end else begin
            tx_push_q <= tx_push_d;
            rx_pop_q  <= rx_pop_d;
            // Refused PULL/PUSH leave the data registers untouched.
            if (|tx_push_d) tx_data_q <= din;
            if (|rx_pop_d)  dout_q    <= rx_words[mindex];
            case (action)
                ACT_PEND:  pend_q[mindex]  <= din[PEND_W-1:0];
                ACT_DIV:   div_q[mindex]   <= din[DIV_W-1:0];
                ACT_GRPS:  grps_q[mindex]  <= din;
                ACT_EN:    en_q[mindex]    <= din[0];
                ACT_SIDES: sides_q[mindex] <= din[SIDES_W-1:0];
                ACT_SHIFT: shift_q[mindex] <= din[SHIFT_W-1:0];
                ACT_IPINS: ipins_q[mindex] <= din;
                ACT_IDIRS: idirs_q[mindex] <= din;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SM; g++) begin : g_imm
        pio_imm_slot u_slot (
            .clk     (clk),
            .rst_n   (reset),
            .load_i  (imm_load[g]),
            .instr_i (din[INSTR_W-1:0]),
            .ready_i (imm_ready[g]),
            .valid_o (imm_valid[g]),
            .instr_o (imm_instr_w[g])
        );
    end

    assign imem_rdata = imem_q[imem_raddr];
    assign full       = tx_full;
    assign empty      = rx_empty;
    assign cfg_pend   = pend_q;
    assign cfg_div    = div_q;
    assign cfg_grps   = grps_q;
    assign cfg_en     = en_q;
    assign cfg_sides  = sides_q;
    assign cfg_shift  = shift_q;
    assign cfg_ipins  = ipins_q;
    assign cfg_idirs  = idirs_q;
    assign tx_push    = tx_push_q;
    assign tx_data    = tx_data_q;
    assign rx_pop     = rx_pop_q;
    assign dout       = dout_q;
    assign imm_instr  = imm_instr_w;
endmodule

// File: tb/tb_pio_host_if.sv
// Directed bench for pio_host_if: hand-computed expectations checked with immediate assertions.
module tb_pio_host_if;
    logic         clk, reset;
    logic [3:0]   action;
    logic [4:0]   index, imem_raddr;
    logic [1:0]   mindex;
    logic [31:0]  din, dout, tx_data;
    logic [3:0]   full, empty, cfg_en, tx_push, tx_full, rx_pop, rx_empty, imm_valid, imm_ready;
    logic [15:0]  imem_rdata;
    logic [19:0]  cfg_pend;
    logic [95:0]  cfg_div;
    logic [127:0] cfg_grps, cfg_ipins, cfg_idirs, rx_data;
    logic [23:0]  cfg_sides;
    logic [63:0]  cfg_shift, imm_instr;
    int n_cmp, n_err;

    pio_host_if dut (
        .clk(clk), .reset(reset), .action(action), .index(index), .mindex(mindex), .din(din),
        .dout(dout), .full(full), .empty(empty), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
        .cfg_pend(cfg_pend), .cfg_div(cfg_div), .cfg_grps(cfg_grps), .cfg_en(cfg_en),
        .cfg_sides(cfg_sides), .cfg_shift(cfg_shift), .cfg_ipins(cfg_ipins), .cfg_idirs(cfg_idirs),
        .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .rx_pop(rx_pop),
        .rx_data(rx_data), .rx_empty(rx_empty), .imm_valid(imm_valid), .imm_instr(imm_instr),
        .imm_ready(imm_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic act(input logic [3:0] a, input logic [4:0] idx, input logic [1:0] mi, input logic [31:0] d);
        action = a; index = idx; mindex = mi; din = d;
        @(posedge clk); #1;
        action = 4'd0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0; action = 4'd0; index = '0; mindex = '0; din = '0; imem_raddr = '0;
        tx_full = '0; rx_data = '0; rx_empty = 4'hF; imm_ready = '0;
        #12;
        chk("rst_pend",  cfg_pend, {4{5'd31}});
        chk("rst_div",   cfg_div, {4{24'h000100}});
        chk("rst_dout",  dout, 0);
        chk("rst_strb",  {tx_push, rx_pop, imm_valid}, 0);
        chk("rst_imem",  imem_rdata, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        act(4'd1, 5'd0, 2'd0, 32'hFFFF_E081);
        act(4'd1, 5'd1, 2'd0, 32'h0000_E000);
        imem_raddr = 5'd0; #1 chk("imem0", imem_rdata, 16'hE081);
        imem_raddr = 5'd1; #1 chk("imem1", imem_rdata, 16'hE000);
        imem_raddr = 5'd5; #1 chk("imem5", imem_rdata, 16'h0000);

        act(4'd2, 5'd0, 2'd0, 32'h0000_0001);
        act(4'd7, 5'd0, 2'd0, 32'hFF00_0280);
        act(4'd5, 5'd0, 2'd0, 32'h0400_0000);
        act(4'd6, 5'd0, 2'd0, 32'h0000_0003);
        chk("pend", cfg_pend, {{3{5'd31}}, 5'd1});
        chk("div",  cfg_div, {{3{24'h000100}}, 24'h000280});
        chk("grps", cfg_grps, 128'h0400_0000);
        chk("en",   cfg_en, 4'b0001);
        act(4'd8,  5'd0, 2'd3, 32'hFFFF_FFFF);
        act(4'd10, 5'd0, 2'd1, 32'hABCD_1234);
        act(4'd11, 5'd0, 2'd2, 32'h1357_9BDF);
        act(4'd12, 5'd0, 2'd3, 32'h2468_ACE0);
        chk("sides", cfg_sides, 24'hFC0000);
        chk("shift", cfg_shift, 64'h0000_0000_1234_0000);
        chk("ipins", cfg_ipins, {32'h0, 32'h1357_9BDF, 64'h0});
        chk("idirs", cfg_idirs, {32'h2468_ACE0, 96'h0});
        act(4'd13, 5'd0, 2'd0, 32'h0000_0000);
        chk("rsvd", {cfg_en, cfg_pend[4:0], tx_push, rx_pop}, {4'b0001, 5'd1, 8'h00});

        act(4'd3, 5'd0, 2'd2, 32'hDEAD_BEEF);
        chk("pull_strb", tx_push, 4'b0100);
        chk("pull_data", tx_data, 32'hDEAD_BEEF);
        idle();
        chk("pull_one", tx_push, 4'b0000);
        tx_full = 4'b0100;
        act(4'd3, 5'd0, 2'd2, 32'h1111_1111);
        chk("pull_full", {tx_push, tx_data}, {4'b0000, 32'hDEAD_BEEF});
        tx_full = 4'b0000;
        action = 4'd3; mindex = 2'd1; din = 32'hA5A5_0001;
        @(posedge clk); #1;
        chk("b2b_0", {tx_push, tx_data}, {4'b0010, 32'hA5A5_0001});
        din = 32'hA5A5_0002;
        @(posedge clk); #1;
        action = 4'd0;
        chk("b2b_1", {tx_push, tx_data}, {4'b0010, 32'hA5A5_0002});
        idle();
        chk("b2b_end", tx_push, 4'b0000);

        rx_data = {32'h0, 32'h0, 32'h1234_5678, 32'h0}; rx_empty = 4'b1101;
        act(4'd4, 5'd0, 2'd1, 32'h0);
        chk("push_pop",  rx_pop, 4'b0010);
        chk("push_dout", dout, 32'h1234_5678);
        idle();
        chk("push_one", rx_pop, 4'b0000);
        rx_data = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0}; rx_empty = 4'b1111;
        act(4'd4, 5'd0, 2'd1, 32'h0);
        chk("push_empty", {rx_pop, dout}, {4'b0000, 32'h1234_5678});

        act(4'd9, 5'd0, 2'd0, 32'hFFFF_E001);
        chk("imm_set", {imm_valid, imm_instr[15:0]}, {4'b0001, 16'hE001});
        idle(); idle();
        chk("imm_hold", {imm_valid, imm_instr[15:0]}, {4'b0001, 16'hE001});
        act(4'd9, 5'd0, 2'd0, 32'h0000_E000);
        chk("imm_ovr", {imm_valid, imm_instr[15:0]}, {4'b0001, 16'hE000});
        imm_ready = 4'b0001;
        idle();
        chk("imm_acc", imm_valid, 4'b0000);
        imm_ready = 4'b0000;
        act(4'd9, 5'd0, 2'd0, 32'h0000_E002);
        imm_ready = 4'b0001;
        act(4'd9, 5'd0, 2'd0, 32'h0000_E003);
        chk("imm_rearm", {imm_valid, imm_instr[15:0]}, {4'b0001, 16'hE003});
        idle();
        imm_ready = 4'b0000;
        chk("imm_acc2", imm_valid, 4'b0000);

        act(4'd9, 5'd0, 2'd3, 32'h0000_E0FF);
        act(4'd3, 5'd0, 2'd0, 32'h5555_AAAA);
        chk("pre_rst", {imm_valid, tx_push}, {4'b1000, 4'b0001});
        reset = 1'b0; imem_raddr = 5'd0;
        #1;
        chk("mid_cfg", {cfg_pend, cfg_div, cfg_en}, {{4{5'd31}}, {4{24'h000100}}, 4'b0000});
        chk("mid_data", {cfg_grps, cfg_ipins[31:0], dout}, 0);
        chk("mid_strb", {tx_push, rx_pop, imm_valid}, 0);
        chk("mid_imem", imem_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
